// File: rtl/wb_qspi_arb.sv
// wb_qspi_arb: round-robin arbiter and region decoder that places an
// instruction-fetch port and a data port in front of one QSPI ROM/RAM
// adapter. Unmapped accesses and ROM writes complete locally, so the
// adapter never receives a write to ROM.
module wb_qspi_arb #(
  parameter logic [7:0]  ROM_REGION = 8'h00,
  parameter logic [7:0]  RAM_REGION = 8'h01,
  parameter logic [31:0] IBUS_DFLT  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        ibus_stb_i,
  input  logic [31:0] ibus_adr_i,
  output logic        ibus_ack_o,
  output logic [31:0] ibus_dat_o,
  input  logic        dbus_stb_i,
  input  logic        dbus_we_i,
  input  logic [3:0]  dbus_be_i,
  input  logic [31:0] dbus_adr_i,
  input  logic [31:0] dbus_dat_i,
  output logic        dbus_ack_o,
  output logic        dbus_err_o,
  output logic [31:0] dbus_dat_o,
  output logic        mem_sel_rom_ram_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [21:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_dat_i
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t      state_q, state_d;
  logic        gnt_r, last_r;
  logic        sel_r, we_r, err_r;
  logic [3:0]  be_r;
  logic [21:0] adr_r;
  logic [31:0] wdat_r, rdat_r;

  logic        ib_win, db_win, grant;
  logic [31:0] win_adr;
  logic        win_we, hit_rom, hit_ram, hit;
  logic [1:0]  unused_adr_bits;

  // Arbitration and decode of the would-be winner; a tie goes to the
  // port that was not granted last.
  always_comb begin
    ib_win  = ibus_stb_i & (~dbus_stb_i | last_r);
    db_win  = dbus_stb_i & (~ibus_stb_i | ~last_r);
    grant   = ib_win | db_win;
    win_adr = db_win ? dbus_adr_i : ibus_adr_i;
    win_we  = db_win & dbus_we_i;
    hit_rom = (win_adr[31:24] == ROM_REGION) & ~win_we;
    hit_ram = (win_adr[31:24] == RAM_REGION);
    hit     = hit_rom | hit_ram;
  end

  // Byte offset is irrelevant to a word-addressed adapter.
  assign unused_adr_bits = win_adr[1:0];

  // State register.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: mapped grants go to the adapter, everything else responds locally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = hit ? MEM : RESP;
      MEM:     if (mem_ack_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted request on grant; capture adapter data on its ack.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      gnt_r  <= 1'b0;
      last_r <= 1'b1;
      sel_r  <= 1'b0;
      we_r   <= 1'b0;
      be_r   <= 4'h0;
      adr_r  <= 22'h0;
      wdat_r <= 32'h0;
      rdat_r <= 32'h0;
      err_r  <= 1'b0;
    end else if (state_q == IDLE && grant) begin
      gnt_r  <= db_win;
      last_r <= db_win;
      sel_r  <= hit_ram;
      we_r   <= win_we;
      be_r   <= db_win ? dbus_be_i : 4'hF;
      adr_r  <= win_adr[23:2];
      wdat_r <= db_win ? dbus_dat_i : 32'h0;
      // Local-completion result; overwritten by the adapter for mapped accesses.
      rdat_r <= db_win ? 32'h0 : IBUS_DFLT;
      err_r  <= db_win & ~hit;
    end else if (state_q == MEM && mem_ack_i) begin
      rdat_r <= mem_dat_i;
      err_r  <= 1'b0;
    end
  end

  assign mem_stb_o         = (state_q == MEM);
  assign mem_sel_rom_ram_o = sel_r;
  assign mem_we_o          = we_r;
  assign mem_be_o          = be_r;
  assign mem_adr_o         = adr_r;
  assign mem_dat_o         = wdat_r;

  assign ibus_ack_o = (state_q == RESP) & ~gnt_r;
  assign dbus_ack_o = (state_q == RESP) &  gnt_r;
  assign dbus_err_o = dbus_ack_o & err_r;
  assign ibus_dat_o = rdat_r;
  assign dbus_dat_o = rdat_r;

endmodule

// File: tb/tb_wb_qspi_arb.sv
// Bench for wb_qspi_arb: requesters push expected responses into per-port
// queues, a monitor pops and compares on every ack, and an adapter model
// answers strobes with address-derived data.
module tb_wb_qspi_arb;

  logic        clk_i = 1'b0, rst_in = 1'b0;
  logic        ibus_stb_i = 1'b0;
  logic [31:0] ibus_adr_i = '0;
  logic        ibus_ack_o;
  logic [31:0] ibus_dat_o;
  logic        dbus_stb_i = 1'b0, dbus_we_i = 1'b0;
  logic [3:0]  dbus_be_i = '0;
  logic [31:0] dbus_adr_i = '0, dbus_dat_i = '0;
  logic        dbus_ack_o, dbus_err_o;
  logic [31:0] dbus_dat_o;
  logic        mem_sel_rom_ram_o, mem_stb_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [21:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_dat_i = '0;

  always #5 clk_i = ~clk_i;

  wb_qspi_arb dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .ibus_stb_i(ibus_stb_i), .ibus_adr_i(ibus_adr_i),
    .ibus_ack_o(ibus_ack_o), .ibus_dat_o(ibus_dat_o),
    .dbus_stb_i(dbus_stb_i), .dbus_we_i(dbus_we_i), .dbus_be_i(dbus_be_i),
    .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i),
    .dbus_ack_o(dbus_ack_o), .dbus_err_o(dbus_err_o), .dbus_dat_o(dbus_dat_o),
    .mem_sel_rom_ram_o(mem_sel_rom_ram_o), .mem_stb_o(mem_stb_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o), .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
  );

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        mapped;
  } exp_t;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  exp_t ibq[$], dbq[$];
  int   order_q[$];
  int   mack_cyc = -10;
  int   stb_cnt = 0;
  bit   adapter_en = 1'b1;
  int   fix_delay = -1;
  bit   fix_dat_en = 1'b0;
  logic [31:0] fix_dat = '0;

  logic        cap_sel, cap_we;
  logic [3:0]  cap_be;
  logic [21:0] cap_adr;
  logic [31:0] cap_dat;

  bit          ib_pend = 0, db_pend = 0, db_we_p = 0;
  logic [31:0] ib_adr_p = '0, db_adr_p = '0, db_dat_p = '0;
  logic [3:0]  db_be_p = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Adapter contents: a fixed word when forced, otherwise a hash of region and word address.
  function automatic logic [31:0] fdat(input logic sel, input logic [21:0] wa);
    if (fix_dat_en) return fix_dat;
    return ({9'd0, sel, wa} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference: what the requester should get back for a request.
  function automatic exp_t model(input bit is_d, input logic we, input logic [31:0] adr);
    exp_t e;
    e.err = 1'b0;
    e.mapped = 1'b1;
    if (adr[31:24] == 8'h00 && !(is_d && we)) e.dat = fdat(1'b0, adr[23:2]);
    else if (adr[31:24] == 8'h01)             e.dat = fdat(1'b1, adr[23:2]);
    else begin
      e.mapped = 1'b0;
      e.dat = is_d ? 32'h0 : 32'h0000_0013;
      e.err = is_d;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_adr();
    logic [7:0] hi;
    case ($urandom_range(0, 3))
      0:       hi = 8'h00;
      2:       hi = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'hFF;
      default: hi = 8'h01;
    endcase
    return {hi, 24'($urandom)};
  endfunction

  // Adapter model: check the strobed request against an outstanding legal one,
  // hold it stable, then ack with data derived from the presented address.
  initial begin
    logic [59:0] cap_v;
    bit ok_i, ok_d;
    int d;
    forever begin
      @(negedge clk_i);
      if (adapter_en && rst_in && mem_stb_o) begin
        stb_cnt++;
        cap_sel = mem_sel_rom_ram_o; cap_we = mem_we_o; cap_be = mem_be_o;
        cap_adr = mem_adr_o; cap_dat = mem_dat_o;
        cap_v = {mem_sel_rom_ram_o, mem_we_o, mem_be_o, mem_adr_o, mem_dat_o};
        ok_i = ib_pend && !mem_we_o && mem_be_o == 4'hF &&
               mem_sel_rom_ram_o == (ib_adr_p[31:24] == 8'h01) && mem_adr_o == ib_adr_p[23:2];
        ok_d = db_pend && (db_adr_p[31:24] == 8'h01 || (db_adr_p[31:24] == 8'h00 && !db_we_p)) &&
               mem_we_o == db_we_p && mem_be_o == db_be_p &&
               mem_sel_rom_ram_o == (db_adr_p[31:24] == 8'h01) && mem_adr_o == db_adr_p[23:2] &&
               (!db_we_p || mem_dat_o == db_dat_p);
        checks++;
        if (!(ok_i || ok_d)) begin
          errors++;
          $display("FAIL mem_request: got sel=%0b we=%0b be=%h adr=%h dat=%h, matches no legal pending request",
                   mem_sel_rom_ram_o, mem_we_o, mem_be_o, mem_adr_o, mem_dat_o);
        end
        d = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 4));
        repeat (d) begin
          @(negedge clk_i);
          chk("mem_stable", 32'({mem_stb_o, cap_v} != {1'b1, mem_sel_rom_ram_o, mem_we_o,
                                 mem_be_o, mem_adr_o, mem_dat_o}), 32'd0);
        end
        mem_dat_i = fdat(mem_sel_rom_ram_o, mem_adr_o);
        mem_ack_i = 1'b1;
        mack_cyc  = cyc;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        mem_dat_i = $urandom;
      end
    end
  end

  // Monitor: pop the expected response on every ack.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_in) begin
        if (ibus_ack_o) begin
          if (ibq.size() == 0) begin
            checks++; errors++;
            $display("FAIL ibus_unexpected_ack: got ack=1 expected ack=0");
          end else begin
            e = ibq.pop_front();
            chk("ibus_dat", ibus_dat_o, e.dat);
            if (e.mapped) chk("ibus_mem_latency", 32'(cyc), 32'(mack_cyc + 1));
          end
          order_q.push_back(0);
        end
        if (dbus_ack_o) begin
          if (dbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL dbus_unexpected_ack: got ack=1 expected ack=0");
          end else begin
            e = dbq.pop_front();
            chk("dbus_dat", dbus_dat_o, e.dat);
            chk("dbus_err", 32'(dbus_err_o), 32'(e.err));
            if (e.mapped) chk("dbus_mem_latency", 32'(cyc), 32'(mack_cyc + 1));
          end
          order_q.push_back(1);
        end
        if ((ibus_ack_o && dbus_ack_o) || (dbus_err_o && !dbus_ack_o)) begin
          checks++; errors++;
          $display("FAIL ack_exclusive: got iack=%0b dack=%0b derr=%0b", ibus_ack_o, dbus_ack_o, dbus_err_o);
        end
      end
    end
  end

  task automatic ibus_txn(input logic [31:0] adr, output int lat);
    int n, t0;
    ibq.push_back(model(1'b0, 1'b0, adr));
    @(posedge clk_i); #1;
    ib_pend = 1; ib_adr_p = adr;
    ibus_adr_i = adr; ibus_stb_i = 1'b1;
    t0 = cyc; n = 0;
    @(negedge clk_i);
    while (!ibus_ack_o && n < 200) begin @(negedge clk_i); n++; end
    if (!ibus_ack_o) begin
      checks++; errors++;
      $display("FAIL ibus_timeout: got no ack within 200 cycles for adr %h", adr);
    end
    lat = cyc - t0;
    @(posedge clk_i); #1;
    ibus_stb_i = 1'b0; ib_pend = 0; ibus_adr_i = $urandom;
  endtask

  task automatic dbus_txn(input logic we, input logic [3:0] be, input logic [31:0] adr,
                          input logic [31:0] dat, output int lat);
    int n, t0;
    dbq.push_back(model(1'b1, we, adr));
    @(posedge clk_i); #1;
    db_pend = 1; db_adr_p = adr; db_we_p = we; db_be_p = be; db_dat_p = dat;
    dbus_adr_i = adr; dbus_we_i = we; dbus_be_i = be; dbus_dat_i = dat; dbus_stb_i = 1'b1;
    t0 = cyc; n = 0;
    @(negedge clk_i);
    while (!dbus_ack_o && n < 200) begin @(negedge clk_i); n++; end
    if (!dbus_ack_o) begin
      checks++; errors++;
      $display("FAIL dbus_timeout: got no ack within 200 cycles for adr %h", adr);
    end
    lat = cyc - t0;
    @(posedge clk_i); #1;
    dbus_stb_i = 1'b0; db_pend = 0; dbus_adr_i = $urandom; dbus_we_i = $urandom;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_acks"},     32'({ibus_ack_o, dbus_ack_o, dbus_err_o}), 32'd0);
    chk({tag, "_mem_ctl"},  32'({mem_stb_o, mem_we_o, mem_sel_rom_ram_o, mem_be_o}), 32'd0);
    chk({tag, "_mem_adr"},  32'(mem_adr_o), 32'd0);
    chk({tag, "_mem_dat"},  mem_dat_o, 32'd0);
    chk({tag, "_ibus_dat"}, ibus_dat_o, 32'd0);
    chk({tag, "_dbus_dat"}, dbus_dat_o, 32'd0);
  endtask

  // Simultaneous requests: acks must alternate starting with ibus.
  task automatic rr_rounds(input int rounds);
    int l1, l2;
    order_q.delete();
    for (int r = 0; r < rounds; r++) begin
      fork
        ibus_txn(32'h0000_0400 + 32'(r * 4), l1);
        dbus_txn(1'b0, 4'hF, 32'h0100_0080 + 32'(r * 4), 32'h0, l2);
      join
    end
    chk("rr_count", 32'(order_q.size()), 32'(2 * rounds));
    for (int i = 0; i < order_q.size() && i < 2 * rounds; i++)
      chk($sformatf("rr_order_%0d", i), 32'(order_q[i]), 32'(i % 2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, s0, acks, n;
    repeat (3) @(negedge clk_i);
    check_reset("reset");
    @(posedge clk_i); #1 rst_in = 1'b1;

    rr_rounds(3);

    // ROM fetch with a slow adapter.
    fix_dat_en = 1; fix_dat = 32'hDEAD_BEEF; fix_delay = 6;
    ibus_txn(32'h0000_0104, lat);
    chk("rom_fetch_adr", 32'(cap_adr), 32'h41);
    chk("rom_fetch_sel", 32'(cap_sel), 32'd0);
    chk("rom_fetch_lat", 32'(lat), 32'd8);
    fix_dat_en = 0; fix_delay = -1;

    // RAM byte write passes through unmodified.
    dbus_txn(1'b1, 4'b0010, 32'h0100_0011, 32'h0000_AB00, lat);
    chk("ram_wr_sel", 32'(cap_sel), 32'd1);
    chk("ram_wr_we",  32'(cap_we),  32'd1);
    chk("ram_wr_be",  32'(cap_be),  32'h2);
    chk("ram_wr_adr", 32'(cap_adr), 32'h4);
    chk("ram_wr_dat", cap_dat, 32'h0000_AB00);

    // ROM write completes locally with an error.
    s0 = stb_cnt;
    dbus_txn(1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678, lat);
    chk("rom_wr_lat", 32'(lat), 32'd1);
    chk("rom_wr_no_stb", 32'(stb_cnt), 32'(s0));

    // Unmapped accesses.
    s0 = stb_cnt;
    ibus_txn(32'h0500_0000, lat);
    chk("unmap_ibus_lat", 32'(lat), 32'd1);
    dbus_txn(1'b0, 4'hF, 32'h0500_0000, 32'h0, lat);
    chk("unmap_dbus_lat", 32'(lat), 32'd1);
    chk("unmap_no_stb", 32'(stb_cnt), 32'(s0));

    // Randomized concurrent traffic on both ports.
    fork
      begin
        int li;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_i);
          ibus_txn(rnd_adr(), li);
        end
      end
      begin
        int ld;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_i);
          dbus_txn(1'($urandom), 4'($urandom), rnd_adr(), $urandom, ld);
        end
      end
    join
    chk("queues_drained", 32'(ibq.size() + dbq.size()), 32'd0);

    // Reset while the adapter is strobed.
    adapter_en = 0;
    @(posedge clk_i); #1;
    ibus_adr_i = 32'h0000_0200; ibus_stb_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!mem_stb_o && n < 10) begin @(negedge clk_i); n++; end
    chk("rstmid_stb_up", 32'(mem_stb_o), 32'd1);
    #2 rst_in = 1'b0;
    #1 chk("rstmid_stb_drop", 32'(mem_stb_o), 32'd0);
    check_reset("rstmid");
    ibus_stb_i = 1'b0;
    @(posedge clk_i); #1 rst_in = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b1; mem_dat_i = 32'hBAD0_BAD0;
    acks = 0;
    repeat (4) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      acks += int'(ibus_ack_o) + int'(dbus_ack_o) + int'(mem_stb_o);
    end
    chk("rstmid_spurious_ack", 32'(acks), 32'd0);
    adapter_en = 1;

    rr_rounds(1);

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_qspi_arb.md
# wb_qspi_arb

Two-port Wishbone arbiter and address decoder in front of the shared QSPI ROM/RAM adapter. It accepts an instruction-fetch port (read-only) and a data port (read/write), grants one at a time with round-robin fairness, decodes the region, and drives the adapter's `sel_rom_ram`, `stb` and word address. It completes unmapped accesses and ROM writes locally so the adapter never sees an illegal ROM write.

## Interface
- `ROM_REGION`, default 8'h00: value of `adr[31:24]` selecting the ROM.
- `RAM_REGION`, default 8'h01: value of `adr[31:24]` selecting the RAM. Must differ from `ROM_REGION`.
- `IBUS_DFLT`, default 32'h0000_0013: instruction data returned for an unmapped fetch.
- `clk_i  in  1  clock`
- `rst_in  in  1  reset, asynchronous, active-low`
- `ibus_stb_i  in  1  fetch request`
- `ibus_adr_i  in  32  fetch byte address`
- `ibus_ack_o  out  1  fetch acknowledge`
- `ibus_dat_o  out  32  fetch data`
- `dbus_stb_i  in  1  data request`
- `dbus_we_i  in  1  data write enable`
- `dbus_be_i  in  4  data byte enables`
- `dbus_adr_i  in  32  data byte address`
- `dbus_dat_i  in  32  write data`
- `dbus_ack_o  out  1  data acknowledge`
- `dbus_err_o  out  1  error, pulses with `dbus_ack_o` for an unmapped access or a ROM write`
- `dbus_dat_o  out  32  read data`
- `mem_sel_rom_ram_o  out  1  0 = ROM, 1 = RAM`
- `mem_stb_o  out  1  adapter strobe`
- `mem_we_o  out  1  adapter write enable`
- `mem_be_o  out  4  adapter byte enables`
- `mem_adr_o  out  22  adapter word address, `adr[23:2]``
- `mem_dat_o  out  32  adapter write data`
- `mem_ack_i  in  1  adapter acknowledge`
- `mem_dat_i  in  32  adapter read data`

## Operation
- **FSM states:** IDLE, MEM, RESP.
- **Registers:**
  - `gnt_r`: 0 = ibus, 1 = dbus.
  - `last_r`: port granted most recently.
  - Latched request: sel, we, be, adr, dat.
  - `rdat_r`, `err_r`.
- **IDLE, arbitration:**
  - Only ibus requesting → grant ibus. Only dbus requesting → grant dbus.
  - Both requesting → grant the port not equal to `last_r`.
  - On grant, latch the winner's attributes and set `last_r`.
  - An ibus request latches `we = 0` and `be = 4'hF`.
- **IDLE, decode of the winner:**
  - `adr[31:24] == ROM_REGION` and not a write → MEM, sel = 0.
  - `adr[31:24] == RAM_REGION` → MEM, sel = 1.
  - Otherwise (unmapped, or a dbus ROM write) → RESP directly, with `err_r` = 1 for dbus.
  - Local read data: ibus gets `IBUS_DFLT`, dbus gets 0.
- **MEM:**
  - `mem_stb_o` = 1. All `mem_*` outputs come from the latched registers and are stable for the whole strobe.
  - On `mem_ack_i`: capture `mem_dat_i` into `rdat_r`, `err_r` = 0, go to RESP.
- **RESP:**
  - For exactly one cycle, assert the granted port's `*_ack_o`, plus `dbus_err_o` = `err_r` if the port is dbus.
  - Data output = `rdat_r`. Then go to IDLE.
  - The non-granted port's ack is 0.
- **Requester rules:** a requester holds stb and its attributes until ack. After ack, a port is not re-sampled until the following IDLE cycle.
- **`mem_ack_i` outside MEM** is ignored.
- Write data and byte enables pass through unmodified; byte-lane handling is the adapter's job.

## Timing
- **Reset values:**
  - State IDLE, `gnt_r` = 0, `last_r` = 1, so ibus wins the first tie.
  - All acks, `dbus_err_o`, `mem_stb_o`, `mem_we_o` = 0.
  - `mem_sel_rom_ram_o` = 0, `mem_be_o` = 0, `mem_adr_o` = 0, `mem_dat_o` = 0.
  - `ibus_dat_o` = 0, `dbus_dat_o` = 0.
- **Memory access latency:** request sampled in IDLE at cycle n → `mem_stb_o` high from n+1 → adapter ack at cycle m → requester ack at m+1. Total overhead is 2 cycles beyond the adapter latency.
- **Local completion latency:** request at n → ack at n+1.
- **Back-to-back requests:** minimum spacing between two grants is 3 cycles (IDLE, MEM, RESP).
- **Reset mid-transaction:** asserting `rst_in` clears all outputs immediately. The adapter restarts in parallel, and requesters must re-issue.
- **Strobe dropped before ack:** a requester that lowers stb after the grant is a protocol violation. The arbiter still completes the latched transaction and pulses ack.

## Test plan
- **ibus only, ROM fetch:** ibus fetch at 0x0000_0104, adapter acks 6 cycles after stb with 0xDEADBEEF → `mem_adr_o` = 0x41, `mem_sel_rom_ram_o` = 0, `ibus_ack_o` 1 cycle after adapter ack, `ibus_dat_o` = 0xDEADBEEF.
- **Simultaneous requests, round-robin:** ibus and dbus request in the same cycle after reset → ibus served first, dbus second. Three repeated simultaneous rounds → grant order I, D, I, D, I, D.
- **RAM byte write:** dbus write to 0x0100_0011, be = 4'b0010, dat = 0x0000_AB00 → sel = 1, `mem_we_o` = 1, `mem_be_o` = 4'b0010, `mem_adr_o` = 0x4, `mem_dat_o` = 0x0000_AB00.
- **ROM write blocked:** dbus write to 0x0000_0020 → `mem_stb_o` never rises, `dbus_ack_o` and `dbus_err_o` both 1 on the next cycle.
- **Unmapped accesses:** ibus fetch at 0x0500_0000 → `ibus_ack_o` on the next cycle, data 0x0000_0013. dbus read at the same address → data 0, `dbus_err_o` = 1.
- **Reset mid-MEM:** pulse `rst_in` low while `mem_stb_o` = 1 → `mem_stb_o` drops asynchronously. A spurious `mem_ack_i` afterwards produces no requester ack.
